pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the successor to the fixed per-stage flip-flop banks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a valid/ready handshake, not a bare stall input.
- Adds flush (bubble injection), an optional one-entry skid buffer for registered upstream ready, and a saturating backpressure counter.
- Each stage boundary in the pipeline instantiates one copy.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_skid_entry.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control bundle
// layout and helpers used by every stage boundary.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 32;

  // Bit positions of the existing control bundle (LSB first).
  localparam int unsigned WE_RF    = 0;
  localparam int unsigned WE_MEM   = 1;
  localparam int unsigned RE_MEM   = 2;
  localparam int unsigned WB_SEL   = 3;
  localparam int unsigned WB_SEL_W = 2;
  localparam int unsigned B_CTRL   = 5;
  localparam int unsigned B_CTRL_W = 2;
  localparam int unsigned HLT      = 7;

  typedef struct packed {
    logic                hlt;
    logic [B_CTRL_W-1:0] b_ctrl;
    logic [WB_SEL_W-1:0] wb_sel;
    logic                re_mem;
    logic                we_mem;
    logic                we_rf;
  } ctrl_t;

  // Control bundle of a bubble: no write enables, no halt.
  function automatic logic [CTRL_W_DEFAULT-1:0] ctrl_zero();
    return '0;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+ctrl+data holding register. Clear wins over load; clear zeroes
// valid and ctrl but keeps data so a bubble costs no data toggles.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_W'(ctrl_zero());
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// one-entry skid buffer and a saturating backpressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned SKID   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_clr;
  logic [CTRL_W-1:0] main_ctrl_src;
  logic [DATA_W-1:0] main_data_src;
  logic              up_xfer;
  logic              dn_xfer;

  assign dn_xfer = main_valid & out_ready;

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clear_i (main_clr),
    .ctrl_i  (main_ctrl_src),
    .data_i  (main_data_src),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  generate
    if (SKID == 0) begin : g_noskid
      // Single register: ready whenever the held entry leaves this cycle.
      assign in_ready      = ~main_valid | out_ready;
      assign up_xfer       = in_valid & in_ready & ~flush;
      assign main_load     = up_xfer;
      assign main_clr      = flush | (dn_xfer & ~up_xfer);
      assign main_ctrl_src = in_ctrl;
      assign main_data_src = in_data;
    end else begin : g_skid
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      logic              skid_load;
      logic              skid_clr;
      logic              main_free;

      // Ready is a flop output: only the skid occupancy gates it.
      assign in_ready  = ~skid_valid;
      assign up_xfer   = in_valid & in_ready & ~flush;
      assign main_free = ~main_valid | out_ready;

      // Skid content is older than any new input, so it refills main first.
      assign main_load     = main_free & (skid_valid | up_xfer);
      assign main_clr      = flush | (dn_xfer & ~main_load);
      assign main_ctrl_src = skid_valid ? skid_ctrl : in_ctrl;
      assign main_data_src = skid_valid ? skid_data : in_data;

      assign skid_load = up_xfer & ~main_free;
      assign skid_clr  = flush | (skid_valid & main_free);

      pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // Stall-cycle counter: clear beats increment, saturates, ignores flush.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (main_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=0 instance and a SKID=1/CNT_W=4 instance
// checked every cycle against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst_n;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, flush0, cnt_clr0;
  logic [7:0]  in_ctrl0, out_ctrl0;
  logic [31:0] in_data0, out_data0;
  logic [15:0] stall_cnt0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, flush1, cnt_clr1;
  logic [7:0]  in_ctrl1, out_ctrl1;
  logic [31:0] in_data1, out_data1;
  logic [3:0]  stall_cnt1;

  int checks;
  int failures;

  // Reference model: each instance is a FIFO of capacity 1 (SKID=0) or 2.
  ent_t        mq[2][2];
  int          mn[2];
  logic [31:0] last_d[2];
  int unsigned mcnt[2];
  int unsigned cmax[2];
  logic [31:0] rx0[$];
  logic [31:0] rx1[$];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .flush(flush0), .cnt_clr(cnt_clr0), .stall_cnt(stall_cnt0)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .flush(flush1), .cnt_clr(cnt_clr1), .stall_cnt(stall_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k]     = 0;
      last_d[k] = '0;
      mcnt[k]   = 0;
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic tick();
    logic        iv[2], ordy[2], fl[2], clr[2], rdy[2], ir[2], ov[2];
    ent_t        ie[2];
    logic [7:0]  oc[2];
    logic [31:0] od[2];
    int unsigned sc[2], ncnt[2];
    #1;
    iv[0] = in_valid0;  ordy[0] = out_ready0; fl[0] = flush0; clr[0] = cnt_clr0;
    iv[1] = in_valid1;  ordy[1] = out_ready1; fl[1] = flush1; clr[1] = cnt_clr1;
    ie[0] = '{c: in_ctrl0, d: in_data0};
    ie[1] = '{c: in_ctrl1, d: in_data1};
    ir[0] = in_ready0;  ir[1] = in_ready1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (k == 1) ? (mn[k] < 2) : (mn[k] == 0 || ordy[k]);
      chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(rdy[k]));
      if (clr[k])                      ncnt[k] = 0;
      else if (mn[k] > 0 && !ordy[k])  ncnt[k] = (mcnt[k] == cmax[k]) ? mcnt[k] : mcnt[k] + 1;
      else                             ncnt[k] = mcnt[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (mn[k] > 0 && ordy[k]) begin
        if (k == 0) rx0.push_back(mq[k][0].d);
        else        rx1.push_back(mq[k][0].d);
        mq[k][0] = mq[k][1];
        mn[k]--;
      end
      if (fl[k]) begin
        mn[k] = 0;
      end else if (iv[k] && rdy[k]) begin
        mq[k][mn[k]] = ie[k];
        mn[k]++;
      end
      if (mn[k] > 0) last_d[k] = mq[k][0].d;
      mcnt[k] = ncnt[k];
    end
    #1;
    ov[0] = out_valid0; oc[0] = out_ctrl0; od[0] = out_data0; sc[0] = 32'(stall_cnt0);
    ov[1] = out_valid1; oc[1] = out_ctrl1; od[1] = out_data1; sc[1] = 32'(stall_cnt1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(mn[k] > 0));
      chk($sformatf("out_ctrl%0d", k), 64'(oc[k]), 64'((mn[k] > 0) ? mq[k][0].c : 8'h00));
      chk($sformatf("out_data%0d", k), 64'(od[k]), 64'((mn[k] > 0) ? mq[k][0].d : last_d[k]));
      chk($sformatf("stall_cnt%0d", k), 64'(sc[k]), 64'(mcnt[k]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov0"}, 64'(out_valid0), 64'd0);
    chk({tag, "_oc0"}, 64'(out_ctrl0), 64'd0);
    chk({tag, "_od0"}, 64'(out_data0), 64'd0);
    chk({tag, "_sc0"}, 64'(stall_cnt0), 64'd0);
    chk({tag, "_ir0"}, 64'(in_ready0), 64'd1);
    chk({tag, "_ov1"}, 64'(out_valid1), 64'd0);
    chk({tag, "_oc1"}, 64'(out_ctrl1), 64'd0);
    chk({tag, "_od1"}, 64'(out_data1), 64'd0);
    chk({tag, "_sc1"}, 64'(stall_cnt1), 64'd0);
    chk({tag, "_ir1"}, 64'(in_ready1), 64'd1);
  endtask

  initial begin
    int cyc;
    int nxt;
    logic acc;
    checks   = 0;
    failures = 0;
    cmax[0]  = 65535;
    cmax[1]  = 15;
    model_reset();

    // Reset values with an entry being offered.
    rst_n = 1'b0;
    in_valid0 = 1'b1; in_ctrl0 = 8'hFF; in_data0 = 32'hDEADBEEF;
    in_valid1 = 1'b1; in_ctrl1 = 8'hFF; in_data1 = 32'hDEADBEEF;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0; cnt_clr0 = 1'b0; cnt_clr1 = 1'b0;
    #2;
    chk_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    rst_n = 1'b1;
    tick();
    chk("first_data0", 64'(out_data0), 64'h0000_0000_DEAD_BEEF);
    chk("first_ctrl0", 64'(out_ctrl0), 64'hFF);
    chk("first_data1", 64'(out_data1), 64'h0000_0000_DEAD_BEEF);
    in_valid1 = 1'b0;

    // Streaming on SKID=0.
    for (int i = 1; i <= 8; i++) begin
      in_data0 = 32'(i);
      in_ctrl0 = 8'(i);
      tick();
      chk("stream_data0", 64'(out_data0), 64'(i));
    end
    in_valid0 = 1'b0;
    tick();

    // Backpressure on SKID=1: stall three cycles once entry 2 is valid.
    cnt_clr1 = 1'b1;
    tick();
    cnt_clr1 = 1'b0;
    rx1.delete();
    nxt = 1;
    cyc = 0;
    while (rx1.size() < 6 && cyc < 40) begin
      in_valid1  = (nxt <= 6);
      in_data1   = 32'(nxt);
      in_ctrl1   = 8'(nxt) | 8'h10;
      out_ready1 = !(cyc >= 2 && cyc <= 4);
      acc        = in_valid1 && in_ready1;
      tick();
      if (acc) nxt++;
      if (cyc == 2) chk("skid_in_ready_drop", 64'(in_ready1), 64'd0);
      cyc++;
    end
    chk("bp_count", 64'(rx1.size()), 64'd6);
    for (int i = 0; i < rx1.size() && i < 6; i++)
      chk($sformatf("bp_order%0d", i), 64'(rx1[i]), 64'(i + 1));
    chk("bp_stall_cnt", 64'(stall_cnt1), 64'd3);
    in_valid1 = 1'b0;

    // Flush with main and skid both holding entries.
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_ctrl1 = 8'h01; in_data1 = 32'hA0;
    tick();
    in_ctrl1 = 8'h02; in_data1 = 32'hB0;
    tick();
    chk("skid_full", 64'(in_ready1), 64'd0);
    in_ctrl1 = 8'h81; in_data1 = 32'h55;
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0; in_valid1 = 1'b0;
    chk("flush_ov1", 64'(out_valid1), 64'd0);
    chk("flush_oc1", 64'(out_ctrl1), 64'd0);
    chk("flush_ir1", 64'(in_ready1), 64'd1);
    out_ready1 = 1'b1;
    repeat (3) tick();
    chk("flush_gone1", 64'(out_valid1), 64'd0);

    // Entry offered during flush to an empty SKID=0 stage is dropped.
    in_valid0 = 1'b1; in_ctrl0 = 8'h81; in_data0 = 32'h77; flush0 = 1'b1;
    tick();
    flush0 = 1'b0; in_valid0 = 1'b0;
    chk("flush_drop0", 64'(out_valid0), 64'd0);
    tick();

    // Counter saturation on the 4-bit instance, then clear during a stall.
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_ctrl1 = 8'h04; in_data1 = 32'h5;
    tick();
    in_valid1 = 1'b0;
    repeat (20) tick();
    chk("cnt_sat", 64'(stall_cnt1), 64'd15);
    cnt_clr1 = 1'b1;
    tick();
    cnt_clr1 = 1'b0;
    chk("cnt_clr", 64'(stall_cnt1), 64'd0);

    // Async reset between edges while entries are held.
    in_valid0 = 1'b1; in_ctrl0 = 8'h09; in_data0 = 32'h99; out_ready0 = 1'b0;
    tick();
    in_valid0 = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    model_reset();
    #1;
    rst_n = 1'b1;
    in_valid0 = 1'b1; in_ctrl0 = 8'h42; in_data0 = 32'h42; out_ready0 = 1'b1;
    tick();
    chk("resume0", 64'(out_data0), 64'h42);
    in_valid0 = 1'b0;

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      in_valid0  = ($urandom_range(0, 9) < 7);
      in_ctrl0   = 8'($urandom);
      in_data0   = $urandom;
      out_ready0 = ($urandom_range(0, 9) < 6);
      flush0     = ($urandom_range(0, 15) == 0);
      cnt_clr0   = ($urandom_range(0, 31) == 0);
      in_valid1  = ($urandom_range(0, 9) < 7);
      in_ctrl1   = 8'($urandom);
      in_data1   = $urandom;
      out_ready1 = ($urandom_range(0, 9) < 5);
      flush1     = ($urandom_range(0, 15) == 0);
      cnt_clr1   = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
